// File: rtl/ma_data_mem_ctrl.sv
// Memory-access stage data-memory controller: req/ack bus transactions with
// store lane formatting, load extraction/extension, stall, misalignment and timeout.
module ma_data_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  MEM_READ,
  input  logic [1:0]  MEM_WRITE,
  input  logic        LOAD_UNSIGNED,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY,
  output logic        MISALIGNED,
  output logic        BUS_ERROR,
  output logic        MEM_BUS_REQ,
  output logic        MEM_BUS_WE,
  output logic [31:0] MEM_BUS_ADDR,
  output logic [31:0] MEM_BUS_WDATA,
  output logic [3:0]  MEM_BUS_BE,
  input  logic [31:0] MEM_BUS_RDATA,
  input  logic        MEM_BUS_ACK
);

  // state   | meaning
  // IDLE    | waiting for a valid aligned op
  // WAIT    | bus request outstanding, counting toward timeout
  // DONE    | result valid, pipeline advances; inputs ignored
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    ld_size;
  logic [1:0]    ld_off;
  logic          ld_uns;

  logic          is_read;
  logic [1:0]    op_size;
  logic          op_valid;
  logic          op_misal;
  logic          op_go;
  logic [3:0]    fmt_be;
  logic [31:0]   fmt_wdata;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   ld_value;

  always_comb begin
    is_read  = (MEM_READ != 2'b00);
    op_size  = is_read ? MEM_READ : MEM_WRITE;
    op_valid = (op_size != 2'b00);
    op_misal = ((op_size == 2'b10) && ADDRESS[0]) ||
               ((op_size == 2'b11) && (ADDRESS[1:0] != 2'b00));
    op_go    = (state == ST_IDLE) && op_valid && !op_misal;
    case (op_size)
      2'b01: begin
        fmt_be    = 4'b0001 << ADDRESS[1:0];
        fmt_wdata = {4{WRITE_DATA[7:0]}};
      end
      2'b10: begin
        fmt_be    = ADDRESS[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{WRITE_DATA[15:0]}};
      end
      default: begin
        fmt_be    = 4'b1111;
        fmt_wdata = WRITE_DATA;
      end
    endcase
  end

  // Stall and misalignment are forced low while reset is held, even if the
  // pipeline register still presents an op.
  assign BUSY        = RESET && (op_go || (state == ST_WAIT));
  assign MISALIGNED  = RESET && (state == ST_IDLE) && op_valid && op_misal;
  assign MEM_BUS_REQ = (state == ST_WAIT);

  always_comb begin
    case (ld_off)
      2'd0:    lb = MEM_BUS_RDATA[7:0];
      2'd1:    lb = MEM_BUS_RDATA[15:8];
      2'd2:    lb = MEM_BUS_RDATA[23:16];
      default: lb = MEM_BUS_RDATA[31:24];
    endcase
    lh = ld_off[1] ? MEM_BUS_RDATA[31:16] : MEM_BUS_RDATA[15:0];
    case (ld_size)
      2'b01:   ld_value = ld_uns ? {24'b0, lb} : {{24{lb[7]}}, lb};
      2'b10:   ld_value = ld_uns ? {16'b0, lh} : {{16{lh[15]}}, lh};
      default: ld_value = MEM_BUS_RDATA;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      ld_size       <= 2'b00;
      ld_off        <= 2'b00;
      ld_uns        <= 1'b0;
      READ_DATA     <= '0;
      BUS_ERROR     <= 1'b0;
      MEM_BUS_WE    <= 1'b0;
      MEM_BUS_ADDR  <= '0;
      MEM_BUS_WDATA <= '0;
      MEM_BUS_BE    <= '0;
    end else begin
      BUS_ERROR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_go) begin
            state         <= ST_WAIT;
            cnt           <= '0;
            MEM_BUS_ADDR  <= {ADDRESS[31:2], 2'b00};
            MEM_BUS_WE    <= !is_read;
            MEM_BUS_BE    <= fmt_be;
            MEM_BUS_WDATA <= fmt_wdata;
            ld_size       <= MEM_READ;
            ld_off        <= ADDRESS[1:0];
            ld_uns        <= LOAD_UNSIGNED;
          end
        end
        ST_WAIT: begin
          if (MEM_BUS_ACK) begin
            if (!MEM_BUS_WE) READ_DATA <= ld_value;
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            BUS_ERROR <= 1'b1;
            if (!MEM_BUS_WE) READ_DATA <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_data_mem_ctrl.sv
// Directed scoreboard bench for ma_data_mem_ctrl: expected bus fields and
// results are queued at issue and compared when the access completes.
module tb_ma_data_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  MEM_READ, MEM_WRITE;
  logic        LOAD_UNSIGNED;
  logic [31:0] ADDRESS, WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY, MISALIGNED, BUS_ERROR;
  logic        MEM_BUS_REQ, MEM_BUS_WE;
  logic [31:0] MEM_BUS_ADDR, MEM_BUS_WDATA;
  logic [3:0]  MEM_BUS_BE;
  logic [31:0] MEM_BUS_RDATA;
  logic        MEM_BUS_ACK;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        berr;
  } exp_t;
  exp_t sb[$];

  ma_data_mem_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .LOAD_UNSIGNED(LOAD_UNSIGNED), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
    .READ_DATA(READ_DATA), .BUSY(BUSY), .MISALIGNED(MISALIGNED),
    .BUS_ERROR(BUS_ERROR), .MEM_BUS_REQ(MEM_BUS_REQ), .MEM_BUS_WE(MEM_BUS_WE),
    .MEM_BUS_ADDR(MEM_BUS_ADDR), .MEM_BUS_WDATA(MEM_BUS_WDATA),
    .MEM_BUS_BE(MEM_BUS_BE), .MEM_BUS_RDATA(MEM_BUS_RDATA), .MEM_BUS_ACK(MEM_BUS_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    MEM_READ = 2'b00; MEM_WRITE = 2'b00; LOAD_UNSIGNED = 1'b0;
    ADDRESS = '0; WRITE_DATA = '0; MEM_BUS_ACK = 1'b0; MEM_BUS_RDATA = '0;
  endtask

  // ack_wait: WAIT cycle in which ACK is raised (0 = never)
  task automatic run_op(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int ack_wait,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata, input logic e_berr,
                        input int e_req, input int e_busy);
    exp_t e;
    exp_t got;
    int req_cnt = 0;
    int busy_cnt = 0;
    @(negedge CLK);
    MEM_READ = rd; MEM_WRITE = wr; LOAD_UNSIGNED = uns; ADDRESS = addr; WRITE_DATA = wd;
    MEM_BUS_ACK = 1'b0; MEM_BUS_RDATA = rdata;
    e.addr = {addr[31:2], 2'b00}; e.we = (rd == 2'b00); e.be = e_be; e.wdata = e_wdata;
    e.rdata = e_rdata; e.berr = e_berr;
    sb.push_back(e);
    #1;
    chk({tag, ":busy_issue"}, 32'(BUSY), 32'd1);
    chk({tag, ":misal_issue"}, 32'(MISALIGNED), 32'd0);
    busy_cnt += int'(BUSY);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge CLK);
      if (!MEM_BUS_REQ) break;
      req_cnt++;
      busy_cnt += int'(BUSY);
      if (req_cnt == 1 || MEM_BUS_ACK) begin
        chk({tag, ":addr"}, MEM_BUS_ADDR, sb[0].addr);
        chk({tag, ":we"}, 32'(MEM_BUS_WE), 32'(sb[0].we));
        chk({tag, ":be"}, 32'(MEM_BUS_BE), 32'(sb[0].be));
        chk({tag, ":wdata"}, MEM_BUS_WDATA, sb[0].wdata);
      end
      MEM_BUS_ACK = (req_cnt == ack_wait);
    end
    MEM_BUS_ACK = 1'b0;
    chk({tag, ":req_dropped"}, 32'(MEM_BUS_REQ), 32'd0);
    chk({tag, ":queue_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, ":read_data"}, READ_DATA, got.rdata);
      chk({tag, ":bus_error"}, 32'(BUS_ERROR), 32'(got.berr));
    end
    chk({tag, ":busy_done"}, 32'(BUSY), 32'd0);
    chk({tag, ":req_cycles"}, req_cnt, e_req);
    chk({tag, ":busy_cycles"}, busy_cnt, e_busy);
    // Inputs still present the op through DONE; it must not be reissued.
    @(negedge CLK);
    chk({tag, ":no_reissue"}, 32'(MEM_BUS_REQ), 32'd0);
    chk({tag, ":berr_pulse_end"}, 32'(BUS_ERROR), 32'd0);
    clear_inputs();
  endtask

  task automatic misal_op(input string tag, input logic [1:0] rd, input logic [31:0] addr,
                          input logic [31:0] e_rdata);
    @(negedge CLK);
    MEM_READ = rd; MEM_WRITE = 2'b00; ADDRESS = addr;
    #1;
    chk({tag, ":misaligned"}, 32'(MISALIGNED), 32'd1);
    chk({tag, ":busy"}, 32'(BUSY), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk({tag, ":no_req"}, 32'(MEM_BUS_REQ), 32'd0);
    end
    chk({tag, ":read_data_kept"}, READ_DATA, e_rdata);
    clear_inputs();
    #1;
    chk({tag, ":misal_clear"}, 32'(MISALIGNED), 32'd0);
  endtask

  initial begin
    RESET = 1'b0;
    clear_inputs();
    #2;
    chk("rst:req", 32'(MEM_BUS_REQ), 32'd0);
    chk("rst:busy", 32'(BUSY), 32'd0);
    chk("rst:misal", 32'(MISALIGNED), 32'd0);
    chk("rst:read_data", READ_DATA, 32'd0);
    chk("rst:bus_error", 32'(BUS_ERROR), 32'd0);
    chk("rst:be", 32'(MEM_BUS_BE), 32'd0);
    chk("rst:addr", MEM_BUS_ADDR, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;

    // ACK while idle is ignored
    @(negedge CLK);
    MEM_BUS_ACK = 1'b1;
    @(negedge CLK);
    chk("idle_ack:req", 32'(MEM_BUS_REQ), 32'd0);
    chk("idle_ack:busy", 32'(BUSY), 32'd0);
    MEM_BUS_ACK = 1'b0;

    run_op("sw", 2'b00, 2'b11, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 3,
           4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 3, 4);
    run_op("lb_s", 2'b01, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80123456, 1,
           4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 1, 2);
    run_op("lb_u", 2'b01, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80123456, 1,
           4'b1000, 32'h0, 32'h00000080, 1'b0, 1, 2);
    run_op("sh", 2'b00, 2'b10, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 2,
           4'b1100, 32'hABCDABCD, 32'h00000080, 1'b0, 2, 3);
    run_op("lh_hi", 2'b10, 2'b00, 1'b0, 32'h202, 32'h0, 32'h7FFF0000, 1,
           4'b1100, 32'h0, 32'h00007FFF, 1'b0, 1, 2);
    run_op("sb", 2'b00, 2'b01, 1'b0, 32'h101, 32'hFFFFFF55, 32'h0, 1,
           4'b0010, 32'h55555555, 32'h00007FFF, 1'b0, 1, 2);
    run_op("lh_lo_s", 2'b10, 2'b00, 1'b0, 32'h200, 32'h0, 32'h12348001, 1,
           4'b0011, 32'h0, 32'hFFFF8001, 1'b0, 1, 2);
    run_op("rd_wins", 2'b11, 2'b11, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 2,
           4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 2, 3);

    misal_op("lw_misal", 2'b11, 32'h101, 32'hCAFEF00D);
    misal_op("lh_misal", 2'b10, 32'h201, 32'hCAFEF00D);

    run_op("lw_timeout", 2'b11, 2'b00, 1'b0, 32'h40, 32'h0, 32'h12345678, 0,
           4'b1111, 32'h0, 32'h0, 1'b1, 64, 65);
    run_op("lw_after_to", 2'b11, 2'b00, 1'b0, 32'h44, 32'h0, 32'h11223344, 1,
           4'b1111, 32'h0, 32'h11223344, 1'b0, 1, 2);

    // Reset in the second WAIT cycle of a store
    @(negedge CLK);
    MEM_WRITE = 2'b11; ADDRESS = 32'h300; WRITE_DATA = 32'h12345678;
    @(negedge CLK);
    chk("rst_mid:req_w1", 32'(MEM_BUS_REQ), 32'd1);
    @(negedge CLK);
    chk("rst_mid:req_w2", 32'(MEM_BUS_REQ), 32'd1);
    RESET = 1'b0;
    #1;
    chk("rst_mid:req", 32'(MEM_BUS_REQ), 32'd0);
    chk("rst_mid:busy", 32'(BUSY), 32'd0);
    chk("rst_mid:we", 32'(MEM_BUS_WE), 32'd0);
    chk("rst_mid:be", 32'(MEM_BUS_BE), 32'd0);
    chk("rst_mid:addr", MEM_BUS_ADDR, 32'd0);
    chk("rst_mid:wdata", MEM_BUS_WDATA, 32'd0);
    chk("rst_mid:read_data", READ_DATA, 32'd0);
    clear_inputs();
    @(negedge CLK);
    RESET = 1'b1;
    run_op("lw_post_rst", 2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1,
           4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0, 1, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
